// File: rtl/lsu_stage.sv
// Memory-access stage: req/gnt/rvalid data-memory handshake, byte-lane alignment and
// load extension, one-beat writeback. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause
);

    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state, state_d;
    logic [5:0]        op_q;
    logic [31:0]       addr_q;
    logic [31:0]       sdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       res_q;
    logic [1:0]        cause_q;
    logic [CNT_W-1:0]  cnt;

    logic              in_mem;
    logic              op_store;
    logic              timed_out;
    logic [1:0]        o;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [3:0]        be;
    logic [31:0]       wdata;

    assign in_mem    = (alucode >= ALU_LB) && (alucode <= ALU_SW);
    assign op_store  = (op_q >= ALU_SB) && (op_q <= ALU_SW);
    assign timed_out = (cnt >= TMO_LAST);
    assign o         = addr_q[1:0];
    assign rd_byte   = mem_rdata[{o, 3'b000} +: 8];
    assign rd_half   = o[1] ? mem_rdata[31:16] : mem_rdata[15:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic in_store;
    logic in_misal;
    assign in_store = (alucode >= ALU_SB) && (alucode <= ALU_SW);
    always_comb begin
        in_misal = 1'b0;
        case (alucode)
            ALU_LH, ALU_LHU, ALU_SH: in_misal = alu_result[0];
            ALU_LW, ALU_SW:          in_misal = |alu_result[1:0];
            default:                 in_misal = 1'b0;
        endcase
    end
`endif

    always_comb begin
        be    = 4'hF;
        wdata = sdata_q;
        case (op_q)
            ALU_LB, ALU_LBU, ALU_SB: begin
                be    = 4'b0001 << o;
                wdata = {4{sdata_q[7:0]}};
            end
            ALU_LH, ALU_LHU, ALU_SH: begin
                be    = 4'b0011 << {o[1], 1'b0};
                wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wdata = sdata_q;
            end
        endcase
    end

    always_comb begin
        load_val = mem_rdata;
        case (op_q)
            ALU_LB:  load_val = {{24{rd_byte[7]}}, rd_byte};
            ALU_LBU: load_val = {24'h0, rd_byte};
            ALU_LH:  load_val = {{16{rd_half[15]}}, rd_half};
            ALU_LHU: load_val = {16'h0, rd_half};
            ALU_LW:  load_val = mem_rdata;
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        wb_valid  = 1'b0;
        wb_we     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        exc_valid = 1'b0;
        exc_cause = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (in_misal)    state_d = S_DONE;
                    else if (in_mem) state_d = S_REQ;
                    else             state_d = S_DONE;
`else
                    state_d = in_mem ? S_REQ : S_DONE;
`endif
                end
            end
            S_REQ: begin
                mem_req   = 1'b1;
                mem_we    = op_store;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = be;
                mem_wdata = op_store ? wdata : '0;
                if (mem_gnt)        state_d = op_store ? S_DONE : S_WAIT;
                else if (timed_out) state_d = S_DONE;
            end
            S_WAIT: begin
                if (mem_rvalid || timed_out) state_d = S_DONE;
            end
            S_DONE: begin
                wb_valid  = 1'b1;
                wb_we     = (cause_q == 2'd0) && !op_store && (rd_q != 5'd0);
                wb_rd     = rd_q;
                wb_data   = res_q;
                exc_valid = (cause_q != 2'd0);
                exc_cause = cause_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            cause_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q    <= alucode;
                    addr_q  <= alu_result;
                    sdata_q <= store_data;
                    rd_q    <= rd_in;
                    res_q   <= alu_result;
                    cnt     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    cause_q <= in_misal ? (in_store ? 2'd2 : 2'd1) : 2'd0;
`else
                    cause_q <= 2'd0;
`endif
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (!mem_gnt && timed_out) cause_q <= 2'd3;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid)     res_q   <= load_val;
                    else if (timed_out) cause_q <= 2'd3;
                end
                default: ;
            endcase
        end
    end

endmodule
